// File: rtl/coef_bank_dbuf_if.sv
// -----------------------------------------------------------------------------
// coef_bank_dbuf_if
//
// Avalon-MM slave-side bundle for the double-buffered coefficient store.
//
// Handshake: there is no waitrequest. A write completes at the clock edge that
// samples AVL_WRITE=1. A read is accepted at the edge that samples AVL_READ=1.
// AVL_READDATA is then qualified by a single-cycle AVL_READDATAVALID pulse
// after the following edge. If AVL_READ and AVL_WRITE are set together, the
// write takes effect and the read returns the value from before the write.
//
// Signals:
//   AVL_ADDRESS        master->slave  word address
//   AVL_DATA           master->slave  write data
//   AVL_WRITE          master->slave  write strobe
//   AVL_READ           master->slave  read strobe
//   AVL_READDATA       slave->master  read data
//   AVL_READDATAVALID  slave->master  read data qualifier
// -----------------------------------------------------------------------------
interface coef_bank_dbuf_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AVL_ADDRESS;
    logic [DATA_WIDTH-1:0] AVL_DATA;
    logic                  AVL_WRITE;
    logic                  AVL_READ;
    logic [DATA_WIDTH-1:0] AVL_READDATA;
    logic                  AVL_READDATAVALID;

    modport master (
        output AVL_ADDRESS,
        output AVL_DATA,
        output AVL_WRITE,
        output AVL_READ,
        input  AVL_READDATA,
        input  AVL_READDATAVALID
    );

    modport slave (
        input  AVL_ADDRESS,
        input  AVL_DATA,
        input  AVL_WRITE,
        input  AVL_READ,
        output AVL_READDATA,
        output AVL_READDATAVALID
    );
endinterface

// File: rtl/coef_bank_dbuf.sv
// -----------------------------------------------------------------------------
// coef_bank_dbuf
//
// Double-buffered FIR coefficient store. Software fills the shadow bank over
// Avalon-MM while the filter reads the active bank. A swap is armed by a CTRL
// write and only lands on a filter sample boundary (i_sample_tick). This keeps
// a convolution from ever mixing two coefficient sets.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_idx          tap index requested by the filter
//   i_sample_tick  one-cycle pulse at the filter sample boundary
//   o_tap          registered active-bank coefficient for i_idx
//   o_mem_ready    active bank holds a valid coefficient set
//   o_dbg_state    swap FSM state (0 = IDLE, 1 = PENDING)
//   avl            Avalon-MM slave port (see coef_bank_dbuf_if)
//
// Address map (word addresses):
//   0..NUM_TAPS-1  shadow coefficients (reads are sign-extended)
//   NUM_TAPS       write: CTRL   bit0 swap request, bit1 clear bitmap+err
//                  read:  STATUS bit0 mem_ready, bit1 swap_pending,
//                                bit2 err, bit3 all_written
//   above          writes ignored, reads return 0
// -----------------------------------------------------------------------------
module coef_bank_dbuf #(
    parameter int NUM_TAPS   = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TEST       = 1,
    parameter int IDX_W      = $clog2(NUM_TAPS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic                  i_sample_tick,
    output logic [COEF_WIDTH-1:0] o_tap,
    output logic                  o_mem_ready,
    output logic                  o_dbg_state,
    coef_bank_dbuf_if.slave       avl
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUM_TAPS);

    // Built-in symmetric low-pass set. It is used when TEST is set, so the
    // filter produces sensible output before software has written anything.
    function automatic logic [COEF_WIDTH-1:0] default_coef(input int idx);
        logic signed [15:0] v;
        case (idx)
            0, 15:   v = 16'sh0565;
            1, 14:   v = 16'sh0BD9;
            2, 13:   v = 16'sh0B0B;
            3, 12:   v = 16'shFF27;
            4, 11:   v = 16'shF3A7;
            5, 10:   v = 16'shFB52;
            6, 9:    v = 16'sh182E;
            7, 8:    v = 16'sh3384;
            default: v = 16'sh0000;
        endcase
        // Signed size cast: truncates when narrower, sign-extends when wider.
        return COEF_WIDTH'(v);
    endfunction

    function automatic logic [COEF_WIDTH-1:0] reset_coef(input int idx);
        return (TEST != 0) ? default_coef(idx) : '0;
    endfunction

    // ------------------------------------------------------------------ state
    logic [COEF_WIDTH-1:0] r_bank [2][NUM_TAPS];
    logic                  r_bank_sel;
    state_t                r_state;
    logic [NUM_TAPS-1:0]   r_bitmap;
    logic                  r_err;
    logic                  r_mem_ready;
    logic [COEF_WIDTH-1:0] r_tap;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    // ------------------------------------------------------------- decoding
    logic                  w_addr_is_tap;
    logic                  w_addr_is_ctrl;
    logic [IDX_W-1:0]      w_tap_addr;
    logic                  w_shadow_sel;
    logic                  w_all_written;
    logic                  w_tap_wr;
    logic                  w_ctrl_wr;
    logic                  w_coef_wr;
    logic                  w_idx_ok;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    assign w_addr_is_tap  = (avl.AVL_ADDRESS < CTRL_ADDR);
    assign w_addr_is_ctrl = (avl.AVL_ADDRESS == CTRL_ADDR);
    assign w_tap_addr     = avl.AVL_ADDRESS[IDX_W-1:0];
    assign w_shadow_sel   = ~r_bank_sel;
    assign w_all_written  = &r_bitmap;
    assign w_tap_wr       = avl.AVL_WRITE && w_addr_is_tap;
    assign w_ctrl_wr      = avl.AVL_WRITE && w_addr_is_ctrl;
    // The shadow bank is frozen while a swap is pending. It is about to go live.
    assign w_coef_wr      = w_tap_wr && (r_state == S_IDLE);

    // An out-of-range tap index can only occur when NUM_TAPS is not a power
    // of two.
    generate
        if ((1 << IDX_W) == NUM_TAPS) begin : g_idx_full
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_part
            assign w_idx_ok = (32'(i_idx) < NUM_TAPS);
        end
    endgenerate

    // -------------------------------------------------------- swap FSM/ctrl
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bank_sel  <= 1'b0;
            r_bitmap    <= '0;
            r_err       <= 1'b0;
            r_mem_ready <= (TEST != 0);
        end else begin
            if (w_tap_wr) begin
                if (r_state == S_IDLE) begin
                    r_bitmap[w_tap_addr] <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end

            // A clear does not cancel a pending swap. It only resets progress
            // tracking and the sticky error.
            if (w_ctrl_wr && avl.AVL_DATA[1]) begin
                r_bitmap <= '0;
                r_err    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ctrl_wr && avl.AVL_DATA[0]) begin
                        if (w_all_written) begin
                            r_state <= S_PENDING;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    // A repeated request while pending needs no handling.
                    if (i_sample_tick) begin
                        r_state     <= S_IDLE;
                        r_bank_sel  <= ~r_bank_sel;
                        r_bitmap    <= '0;
                        r_mem_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------- coefficient RAM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_bank[b][t] <= reset_coef(t);
                end
            end
        end else if (w_coef_wr) begin
            r_bank[w_shadow_sel][w_tap_addr] <= avl.AVL_DATA[COEF_WIDTH-1:0];
        end
    end

    // ----------------------------------------------------------- tap output
    // This uses the pre-swap bank_sel at the tick edge. The new set therefore
    // shows up for the index sampled one edge later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tap <= '0;
        end else if (w_idx_ok) begin
            r_tap <= r_bank[r_bank_sel][i_idx];
        end else begin
            r_tap <= '0;
        end
    end

    // ------------------------------------------------------------ read path
    always_comb begin
        w_rd_mux = '0;
        if (w_addr_is_tap) begin
            w_rd_mux = DATA_WIDTH'($signed(r_bank[w_shadow_sel][w_tap_addr]));
        end else if (w_addr_is_ctrl) begin
            w_rd_mux[3:0] = {w_all_written, r_err,
                             (r_state == S_PENDING), r_mem_ready};
        end
    end

    // Reads sample registers before this edge's update. A read issued with a
    // write therefore returns the value from before the write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= avl.AVL_READ;
            if (avl.AVL_READ) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign o_tap                 = r_tap;
    assign o_mem_ready           = r_mem_ready;
    assign o_dbg_state           = r_state;
    assign avl.AVL_READDATA      = r_rdata;
    assign avl.AVL_READDATAVALID = r_rvalid;

endmodule

// File: tb/tb_coef_bank_dbuf.sv
// -----------------------------------------------------------------------------
// tb_coef_bank_dbuf
//
// Two DUTs share one clock: dut1 is built with TEST=1 and dut0 with TEST=0.
// Avalon read responses go through per-DUT expected queues. o_tap and
// o_mem_ready are compared directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_coef_bank_dbuf;
  localparam int NT = 16;
  localparam int CW = 16;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int IW = 4;

  // ---------------------------------------------------- clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst0;
  logic [IW-1:0] idx1, idx0;
  logic tick1, tick0;
  logic [CW-1:0] tap1, tap0;
  logic rdy1, rdy0, st1, st0;

  coef_bank_dbuf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  coef_bank_dbuf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();

  coef_bank_dbuf #(.NUM_TAPS(NT), .COEF_WIDTH(CW), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .TEST(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_idx(idx1), .i_sample_tick(tick1),
    .o_tap(tap1), .o_mem_ready(rdy1), .o_dbg_state(st1), .avl(if1)
  );

  coef_bank_dbuf #(.NUM_TAPS(NT), .COEF_WIDTH(CW), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .TEST(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_idx(idx0), .i_sample_tick(tick0),
    .o_tap(tap0), .o_mem_ready(rdy0), .o_dbg_state(st0), .avl(if0)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q0[$];
  string name_q1[$];
  string name_q0[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if1.AVL_READDATAVALID === 1'b1) begin
      if (exp_q1.size() == 0) begin
        chk("dut1_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk(name_q1.pop_front(), 32'(if1.AVL_READDATA), 32'(exp_q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (if0.AVL_READDATAVALID === 1'b1) begin
      if (exp_q0.size() == 0) begin
        chk("dut0_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk(name_q0.pop_front(), 32'(if0.AVL_READDATA), 32'(exp_q0.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                         input logic w, input logic r);
    if (d == 1) begin
      if1.AVL_ADDRESS = a; if1.AVL_DATA = v; if1.AVL_WRITE = w; if1.AVL_READ = r;
    end else begin
      if0.AVL_ADDRESS = a; if0.AVL_DATA = v; if0.AVL_WRITE = w; if0.AVL_READ = r;
    end
  endtask

  task automatic push_exp(input int d, input logic [DW-1:0] e, input string nm);
    if (d == 1) begin
      exp_q1.push_back(e); name_q1.push_back(nm);
    end else begin
      exp_q0.push_back(e); name_q0.push_back(nm);
    end
  endtask

  task automatic wr(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    set_bus(d, a, v, 1'b1, 1'b0);
    step();
    set_bus(d, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] a, input logic [DW-1:0] e,
                    input string nm);
    push_exp(d, e, nm);
    set_bus(d, a, '0, 1'b0, 1'b1);
    step();
    set_bus(d, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rdwr(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                      input logic [DW-1:0] e, input string nm);
    push_exp(d, e, nm);
    set_bus(d, a, v, 1'b1, 1'b1);
    step();
    set_bus(d, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic pulse_tick(input int d);
    if (d == 1) tick1 = 1'b1; else tick0 = 1'b1;
    step();
    tick1 = 1'b0;
    tick0 = 1'b0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    rst1 = 1'b1; rst0 = 1'b1;
    idx1 = '0; idx0 = '0; tick1 = 1'b0; tick0 = 1'b0;
    set_bus(1, '0, '0, 1'b0, 1'b0);
    set_bus(0, '0, '0, 1'b0, 1'b0);
    step();
    step();

    // Reset state for both builds
    chk("rst_tap1", 32'(tap1), 32'h0);
    chk("rst_rdy1", 32'(rdy1), 32'h1);
    chk("rst_rvalid1", 32'(if1.AVL_READDATAVALID), 32'h0);
    chk("rst_rdata1", 32'(if1.AVL_READDATA), 32'h0);
    chk("rst_state1", 32'(st1), 32'h0);
    chk("rst_tap0", 32'(tap0), 32'h0);
    chk("rst_rdy0", 32'(rdy0), 32'h0);
    rst1 = 1'b0; rst0 = 1'b0;

    // Default set through the registered tap path
    idx1 = 4'd7; step(); chk("tap_default_7", 32'(tap1), 32'h3384);
    idx1 = 4'd3; step(); chk("tap_default_3", 32'(tap1), 32'hFF27);
    rd(1, 16'd16, 16'h0001, "status_after_reset");
    rd(1, 16'd4, 16'hF3A7, "shadow_read_negative");
    rd(1, 16'd19, 16'h0000, "read_above_ctrl");
    rdwr(1, 16'd5, 16'h1234, 16'hFB52, "read_with_write_pre");
    rd(1, 16'd5, 16'h1234, "read_after_write");

    // Full fill with k+1, then swap on a later tick
    for (int k = 0; k < NT; k++) wr(1, 16'(k), 16'(k + 1));
    wr(1, 16'd16, 16'h0001);
    chk("state_pending", 32'(st1), 32'h1);
    rd(1, 16'd16, 16'h000B, "status_pending");
    idx1 = 4'd2;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("tap_hold_old", 32'(tap1), 32'h0B0B);
    end
    pulse_tick(1);
    chk("tap_at_tick_edge", 32'(tap1), 32'h0B0B);
    step();
    chk("tap_after_swap", 32'(tap1), 32'h0003);
    rd(1, 16'd16, 16'h0001, "status_after_swap");
    rd(1, 16'd0, 16'h0565, "shadow_is_old_active");

    // Incomplete fill: request dropped, err set
    for (int k = 0; k < NT - 1; k++) wr(1, 16'(k), 16'(16'h20 + k));
    wr(1, 16'd16, 16'h0001);
    rd(1, 16'd16, 16'h0005, "status_partial_err");
    pulse_tick(1);
    step();
    chk("tap_no_swap", 32'(tap1), 32'h0003);
    wr(1, 16'd16, 16'h0002);
    rd(1, 16'd16, 16'h0001, "status_after_clear");

    // Write while pending is ignored and flags err
    for (int k = 0; k < NT; k++) wr(1, 16'(k), 16'(16'h100 + k));
    wr(1, 16'd16, 16'h0001);
    wr(1, 16'd0, 16'h7FFF);
    rd(1, 16'd16, 16'h000F, "status_pending_err");
    pulse_tick(1);
    idx1 = 4'd0;
    step();
    chk("tap_new_set_0", 32'(tap1), 32'h0100);
    rd(1, 16'd0, 16'h0001, "shadow_prev_active");
    rd(1, 16'd16, 16'h0005, "status_err_sticky");

    // TEST=0 build: starts empty, becomes ready at the swap edge
    idx0 = 4'd2;
    step();
    chk("tap0_zero", 32'(tap0), 32'h0);
    rd(0, 16'd16, 16'h0000, "status0_after_reset");
    for (int k = 0; k < NT; k++) wr(0, 16'(k), 16'(16'h10 + k));
    wr(0, 16'd16, 16'h0001);
    chk("rdy0_before_tick", 32'(rdy0), 32'h0);
    pulse_tick(0);
    chk("rdy0_at_tick", 32'(rdy0), 32'h1);
    step();
    chk("tap0_swapped", 32'(tap0), 32'h0012);

    // Reset while a swap is pending
    for (int k = 0; k < NT; k++) wr(0, 16'(k), 16'(16'h40 + k));
    wr(0, 16'd16, 16'h0001);
    rd(0, 16'd16, 16'h000B, "status0_pending");
    rst0 = 1'b1; step(); rst0 = 1'b0;
    chk("rdy0_after_rst", 32'(rdy0), 32'h0);
    chk("state0_after_rst", 32'(st0), 32'h0);
    rd(0, 16'd16, 16'h0000, "status0_after_rst");
    pulse_tick(0);
    step();
    chk("tap0_after_rst_tick", 32'(tap0), 32'h0);

    // Reset mid-fill: the bitmap must restart from empty
    for (int k = 0; k < 8; k++) wr(0, 16'(k), 16'(16'h50 + k));
    rst0 = 1'b1; step(); rst0 = 1'b0;
    for (int k = 8; k < NT; k++) wr(0, 16'(k), 16'(16'h50 + k));
    wr(0, 16'd16, 16'h0001);
    rd(0, 16'd16, 16'h0004, "status0_midfill_rst");

    step(); step(); step();
    chk("dut1_reads_drained", 32'(exp_q1.size()), 32'd0);
    chk("dut0_reads_drained", 32'(exp_q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/coef_bank_dbuf.md
# coef_bank_dbuf

Parametrised, double-buffered FIR coefficient store. It sits between the Avalon-MM control bus and the filter datapath. Software writes a complete new coefficient set into a shadow bank while the filter keeps reading the active bank. A requested swap takes effect only on a sample boundary, so a convolution never mixes coefficients from two sets.

## Interface
- NUM_TAPS, 16, number of taps per bank (2..256)
- COEF_WIDTH, 16, coefficient width in bits (≤ DATA_WIDTH)
- ADDR_WIDTH, 16, Avalon word-address width
- DATA_WIDTH, 16, Avalon data width (≥ 4)
- TEST, 1, preload default coefficients into both banks at reset
- IDX_W, $clog2(NUM_TAPS), tap index width (derived)

Clock and reset: one clock; reset is synchronous and active-high.

- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_idx  in  IDX_W  tap index requested by filter
- i_sample_tick  in  1  one-cycle pulse at filter sample boundary
- o_tap  out  COEF_WIDTH  active-bank coefficient at registered i_idx
- o_mem_ready  out  1  active bank holds a valid coefficient set
- AVL_ADDRESS  in  ADDR_WIDTH  word address
- AVL_DATA  in  DATA_WIDTH  write data
- AVL_WRITE  in  1  write strobe
- AVL_READ  in  1  read strobe
- AVL_READDATA  out  DATA_WIDTH  read data
- AVL_READDATAVALID  out  1  read data qualifier

## Operation
- Two banks of NUM_TAPS × COEF_WIDTH registers. A bank_sel bit selects the active bank; the other bank is the shadow.
- Address map:
  - 0..NUM_TAPS-1: shadow coefficient. Write stores AVL_DATA[COEF_WIDTH-1:0] and sets that tap's bit in the written bitmap. Read returns the shadow value sign-extended to DATA_WIDTH.
  - NUM_TAPS, CTRL on write: bit0 = swap request; bit1 = clear bitmap and err.
  - NUM_TAPS, STATUS on read: bit0 = o_mem_ready; bit1 = swap_pending; bit2 = err; bit3 = all_written.
  - Above NUM_TAPS: writes ignored, reads return 0.
- Swap FSM states:
  - IDLE → PENDING on a CTRL write with bit0=1 when all_written=1.
  - If all_written=0, the request is dropped, err is set and the state stays IDLE.
  - PENDING → IDLE on i_sample_tick. That edge flips bank_sel, clears the bitmap and sets o_mem_ready=1.
- While PENDING, coefficient writes are ignored and set err. A repeated swap request is a no-op.
- After a swap, the new shadow holds the previous active set. A full rewrite is still required before the next swap, because the bitmap is cleared.
- CTRL bit1 clears the bitmap and err. It does not cancel a pending swap.
- Reset:
  - bank_sel=0, state IDLE, bitmap=0, err=0, o_tap=0, AVL_READDATA=0, AVL_READDATAVALID=0.
  - TEST=1: both banks load the default set. Index 0..15 = 0565, 0BD9, 0B0B, FF27, F3A7, FB52, 182E, 3384, 3384, 182E, FB52, F3A7, FF27, 0B0B, 0BD9, 0565 (hex), truncated or sign-extended to COEF_WIDTH. Indices ≥16 load 0. o_mem_ready=1.
  - TEST=0: all coefficients are 0 and o_mem_ready=0.
- A reset mid-operation abandons the pending swap and partial writes, and restores the reset state above.

## Timing
- o_tap is registered: the value for i_idx sampled at edge N appears after edge N. i_idx ≥ NUM_TAPS yields 0.
- Reads: AVL_READDATA and AVL_READDATAVALID are asserted one cycle after AVL_READ. Valid is a single-cycle pulse. There is no waitrequest; reads and writes complete at their strobe edge.
- AVL_READ and AVL_WRITE together: the write takes effect and the read returns the pre-write value.
- Swap timing:
  - A CTRL write at edge N makes swap_pending visible after N.
  - An i_sample_tick sampled at edge M > N swaps at M, so o_tap reflects the new bank for the index sampled at M+1.
  - A tick coincident with the request edge N is not used.
- A coefficient write coincident with the swapping tick is ignored and sets err, because the state is still PENDING at that edge.

## Test plan
- Reset with TEST=1, then i_idx=7 → o_tap=0x3384 one cycle later; i_idx=3 → 0xFF27; o_mem_ready=1; STATUS read = 0x0001.
- Write shadow taps 0..15 with value k+1, CTRL=0x1, hold i_idx=2, pulse i_sample_tick 5 cycles later → o_tap stays 0x0B0B until the tick edge, then reads 0x0003; STATUS = 0x0001.
- Write only taps 0..14, then CTRL=0x1 → no swap on the following tick, STATUS = 0x0005 (err set); CTRL=0x2 → STATUS = 0x0001.
- While PENDING, write tap 0 = 0x7FFF → ignored; shadow read of address 0 after the swap returns the old active value; err=1.
- Reset with TEST=0 → o_mem_ready=0, o_tap=0. Complete a fill and swap → o_mem_ready rises at the tick edge. Assert i_rst mid-fill → bitmap and pending cleared, o_mem_ready=0.
- Read address NUM_TAPS+3 → AVL_READDATAVALID one cycle later with data 0. Read a shadow tap holding 0xF3A7 with DATA_WIDTH=16 → 0xF3A7.
